// File: rtl/vel_pkg.sv
// Shared definitions for the logo velocity control slice.
//   - rpt_state_e   : per-button auto-repeat FSM encoding
//   - DEF_*         : default timing constants for the 12 MHz pixel clock
//   - VEL_W         : default width of the velocity level
package vel_pkg;

  localparam int VEL_W = 4;

  // 12 MHz clock: 10 ms debounce, 0.5 s before repeat, 100 ms between repeats.
  localparam int DEF_DEBOUNCE_CYCLES = 120000;
  localparam int DEF_REPEAT_DELAY    = 6000000;
  localparam int DEF_REPEAT_PERIOD   = 1200000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw push-button into a debounced level and step pulses.
//   clk  : pixel clock
//   clr  : synchronous active-high reset
//   btn  : raw button, asynchronous to clk
//   st   : debounced stable level (1 = pressed)
//   step : one-cycle pulse on a new press and on each auto-repeat tick
// A button already held when clr asserts is not treated as a new press; it
// must be released (debounced) and pressed again before it produces steps.
module btn_debounce
  import vel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  output logic st,
  output logic step
);

  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DC_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int RC_W   = $clog2(RC_MAX);

  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);
  localparam logic            BTN_REL = BTN_ACTIVE_LOW; // raw level when released

  logic [1:0]      sync_q;
  logic [1:0]      fill_q;   // marks when sync_q holds real samples again
  logic            lvl;
  logic [DC_W-1:0] dc;
  logic [DC_W-1:0] ac;       // consecutive released samples while disarmed
  logic            armed;

  rpt_state_e      state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= {2{BTN_REL}};
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  assign lvl = sync_q[1] ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (clr) begin
      st    <= 1'b0;
      dc    <= '0;
      ac    <= '0;
      armed <= 1'b0;
    end else begin
      if (lvl == st) begin
        dc <= '0;
      end else if (dc == DC_LAST) begin
        st <= lvl;
        dc <= '0;
      end else begin
        dc <= dc + 1'b1;
      end

      // Arm once a genuine release has been seen: either a debounced 1->0,
      // or a full debounce window of released samples after reset.
      if (!armed) begin
        if (st && !lvl && dc == DC_LAST) begin
          armed <= 1'b1;
        end else if (!st && !lvl && fill_q[1]) begin
          if (ac == DC_LAST) armed <= 1'b1;
          else               ac    <= ac + 1'b1;
        end else begin
          ac <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  // NOTE: all combinational outputs get a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        // In IDLE, st=1 can only mean a fresh press (DELAY/REPEAT leave on st=0).
        if (st && armed) begin
          step    = 1'b1;
          state_d = DELAY;
          rc_d    = '0;
        end
      end
      DELAY: begin
        if (!st) begin
          state_d = IDLE;
          rc_d    = '0;
        end else if (rc_q == RD_LAST) begin
          step    = 1'b1;
          state_d = REPEAT;
          rc_d    = '0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!st) begin
          state_d = IDLE;
          rc_d    = '0;
        end else if (rc_q == RP_LAST) begin
          step = 1'b1;
          rc_d = '0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rc_d    = '0;
      end
    endcase
  end

  a_cycle_params: assert property (@(posedge clk)
    DEBOUNCE_CYCLES >= 2 && REPEAT_DELAY >= 2 && REPEAT_PERIOD >= 2)
    else $error("btn_debounce: cycle parameters must be >= 2");

endmodule

// File: rtl/vel_ctrl.sv
// Logo velocity control: two conditioned buttons drive a saturating level.
//   clk         : pixel clock (shared with the logo block)
//   clr         : synchronous active-high reset
//   inc_vel     : raw increment button, asynchronous
//   dec_vel     : raw decrement button, asynchronous
//   vel         : current velocity level
//   vel_changed : one-cycle pulse in the cycle vel takes a new value
//   at_max      : vel == VEL_MAX
//   at_min      : vel == VEL_MIN
module vel_ctrl
  import vel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = vel_pkg::DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = vel_pkg::DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = vel_pkg::DEF_REPEAT_PERIOD,
  parameter int VEL_W           = vel_pkg::VEL_W,
  parameter int VEL_MIN         = 1,
  parameter int VEL_MAX         = 15,
  parameter int VEL_RESET       = 4,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc_vel,
  input  logic             dec_vel,
  output logic [VEL_W-1:0] vel,
  output logic             vel_changed,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [VEL_W-1:0] VMIN = VEL_W'(VEL_MIN);
  localparam logic [VEL_W-1:0] VMAX = VEL_W'(VEL_MAX);
  localparam logic [VEL_W-1:0] VRST = VEL_W'(VEL_RESET);

  logic             inc_st, dec_st;
  logic             inc_step, dec_step;
  logic [1:0]       unused_st;   // stable levels are not needed at this level
  logic [VEL_W-1:0] vel_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_inc (
    .clk  (clk),
    .clr  (clr),
    .btn  (inc_vel),
    .st   (inc_st),
    .step (inc_step)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_dec (
    .clk  (clk),
    .clr  (clr),
    .btn  (dec_vel),
    .st   (dec_st),
    .step (dec_step)
  );

  assign unused_st = {inc_st, dec_st};

  // Coincident steps cancel; saturation holds instead of wrapping.
  always_comb begin
    vel_d = vel;
    if (inc_step && !dec_step && vel < VMAX) begin
      vel_d = vel + 1'b1;
    end else if (dec_step && !inc_step && vel > VMIN) begin
      vel_d = vel - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vel         <= VRST;
      vel_changed <= 1'b0;
    end else begin
      vel         <= vel_d;
      vel_changed <= (vel_d != vel);
    end
  end

  assign at_max = (vel == VMAX);
  assign at_min = (vel == VMIN);

  a_vel_params: assert property (@(posedge clk)
    VEL_MIN <= VEL_RESET && VEL_RESET <= VEL_MAX && VEL_MAX < (2 ** VEL_W))
    else $error("vel_ctrl: need VEL_MIN <= VEL_RESET <= VEL_MAX < 2**VEL_W");

endmodule

// File: tb/tb_vel_ctrl.sv
// Scoreboard bench for vel_ctrl with short timing parameters.
module tb_vel_ctrl;

  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int VMIN = 1;
  localparam int VMAX = 15;
  localparam int VRST = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       inc_vel;
  logic       dec_vel;
  logic [3:0] vel;
  logic       vel_changed;
  logic       at_max;
  logic       at_min;

  vel_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .VEL_W           (4),
    .VEL_MIN         (VMIN),
    .VEL_MAX         (VMAX),
    .VEL_RESET       (VRST),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .inc_vel     (inc_vel),
    .dec_vel     (dec_vel),
    .vel         (vel),
    .vel_changed (vel_changed),
    .at_max      (at_max),
    .at_min      (at_min)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int v;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int v, input int at);
    exp_t e;
    e.v  = v;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; clr is seen by exactly one rising edge.
  task automatic do_reset();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("rst_vel", vel, VRST);
    check("rst_vel_changed", vel_changed, 0);
    check("rst_at_max", at_max, 0);
    check("rst_at_min", at_min, 0);
  endtask

  task automatic phase_end(input string name, input int v);
    check({name, "_pending"}, sb.size(), 0);
    check({name, "_vel"}, vel, v);
    check({name, "_at_max"}, at_max, (v == VMAX));
    check({name, "_at_min"}, at_min, (v == VMIN));
    sb.delete();
  endtask

  // Monitor: every vel_changed pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (vel_changed === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_vel_changed", vel_changed, 0);
      end else begin
        e = sb.pop_front();
        check("step_vel", vel, e.v);
        check("step_cycle", cyc, e.at);
        check("step_at_max", at_max, (e.v == VMAX));
        check("step_at_min", at_min, (e.v == VMIN));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    clr     = 1'b0;
    inc_vel = 1'b0;
    dec_vel = 1'b0;
    tick(2);

    // 1: single press, 2 sync + 4 debounce + 1 register = 7 cycles.
    do_reset();
    tick(10);
    n = cyc;
    inc_vel = 1'b1;
    push(5, n + 7);
    tick(10);
    inc_vel = 1'b0;
    tick(30);
    phase_end("t1", 5);

    // 2: 3-cycle glitches never reach the debounce threshold.
    do_reset();
    tick(10);
    repeat (5) begin
      inc_vel = 1'b1;
      tick(3);
      inc_vel = 1'b0;
      tick(3);
    end
    tick(20);
    phase_end("t2", 4);

    // 3: held dec: steps at +7, +27, +35; saturates at VMIN afterwards.
    do_reset();
    tick(10);
    n = cyc;
    dec_vel = 1'b1;
    push(3, n + 7);
    push(2, n + 27);
    push(1, n + 35);
    tick(60);
    dec_vel = 1'b0;
    tick(30);
    phase_end("t3", 1);

    // 4: repeated short presses climb to VMAX; the 12th press is absorbed.
    do_reset();
    tick(10);
    for (int k = 0; k < 12; k++) begin
      n = cyc;
      inc_vel = 1'b1;
      if (k < 11) push(5 + k, n + 7);
      tick(10);
      inc_vel = 1'b0;
      tick(10);
    end
    tick(10);
    phase_end("t4", 15);

    // 5: coincident presses cancel; inc keeps repeating after dec releases.
    do_reset();
    tick(10);
    n = cyc;
    inc_vel = 1'b1;
    dec_vel = 1'b1;
    tick(10);
    dec_vel = 1'b0;
    push(5, n + 27);
    push(6, n + 35);
    tick(20);
    inc_vel = 1'b0;
    tick(30);
    phase_end("t5", 6);

    // 6: reset while held in DELAY; the held press must not re-trigger.
    do_reset();
    tick(10);
    n = cyc;
    inc_vel = 1'b1;
    push(5, n + 7);
    tick(15);
    do_reset();
    tick(60);
    phase_end("t6_hold", 4);
    inc_vel = 1'b0;
    tick(10);
    n = cyc;
    inc_vel = 1'b1;
    push(5, n + 7);
    tick(10);
    inc_vel = 1'b0;
    tick(30);
    phase_end("t6_repress", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
